// File: rtl/mux8_rr_sched.sv
// Round-robin scheduler for a shared 8:1 bit-select mux: arbitrates req,
// holds each grant for at most MAX_HOLD cycles and drives the registered select.
module mux8_rr_sched #(
  parameter int MAX_HOLD = 4,
  parameter int CNT_W    = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req,
  input  logic [7:0] i,
  output logic [7:0] gnt,
  output logic [2:0] s,
  output logic       valid,
  output logic       out
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t           state, state_n;
  logic [2:0]       ptr, ptr_n, s_n;
  logic [7:0]       gnt_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             rel, arb, found;
  logic [2:0]       base, win;

  // First set bit of r at or above b, wrapping 7->0; returns {found, index}.
  function automatic logic [3:0] rr_pick(input logic [7:0] r, input logic [2:0] b);
    logic [3:0] res;
    logic [2:0] idx;
    res = '0;
    for (int k = 7; k >= 0; k--) begin
      idx = b + 3'(k);
      if (r[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves a
    // variable unassigned, which would otherwise infer a latch.
    state_n = state;
    ptr_n   = ptr;
    s_n     = s;
    gnt_n   = gnt;
    cnt_n   = cnt;

    rel = (state == GRANT) && (!req[s] || (cnt == CNT_W'(MAX_HOLD - 1)));
    arb = (state == IDLE) || rel;
    base = (state == IDLE) ? ptr : s + 3'd1;
    {found, win} = rr_pick(req, base);

    if (rel) ptr_n = s + 3'd1;

    if (arb) begin
      if (found) begin
        state_n = GRANT;
        s_n     = win;
        gnt_n   = 8'h01 << win;
        cnt_n   = '0;
      end else begin
        // s keeps its last value while idle; valid and gnt mask it off.
        state_n = IDLE;
        gnt_n   = '0;
        cnt_n   = '0;
      end
    end else begin
      cnt_n = cnt + CNT_W'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ptr   <= '0;
      s     <= '0;
      gnt   <= '0;
      cnt   <= '0;
    end else begin
      state <= state_n;
      ptr   <= ptr_n;
      s     <= s_n;
      gnt   <= gnt_n;
      cnt   <= cnt_n;
    end
  end

  assign valid = (state == GRANT);
  assign out   = valid & i[s];

endmodule

// File: tb/tb_mux8_rr_sched.sv
// Scoreboard bench for mux8_rr_sched: directed stimulus pushes the expected
// per-cycle view; a negedge monitor pops and compares.
module tb_mux8_rr_sched;

  logic       clk = 1'b0;
  logic       rst, valid, out;
  logic [7:0] req, i, gnt;
  logic [2:0] s;

  int n_checks = 0;
  int n_err    = 0;

  typedef struct {
    int         ev;
    int         es;
    int         ec;
    logic [7:0] gnt;
    logic       o;
    string      nm;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  mux8_rr_sched #(.MAX_HOLD(4), .CNT_W(8)) dut (
    .clk   (clk),
    .rst   (rst),
    .req   (req),
    .i     (i),
    .gnt   (gnt),
    .s     (s),
    .valid (valid),
    .out   (out)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Drive inputs just after a rising edge and queue the expected view of the
  // registers loaded by that edge (ev<0: no check; es/ec<0: field not checked).
  task automatic step(input logic r, input logic [7:0] rq, input logic [7:0] d,
                      input int ev, input int es, input int ec, input string nm);
    exp_t e;
    @(posedge clk);
    #1;
    rst = r;
    req = rq;
    i   = d;
    if (ev >= 0) begin
      e.ev  = ev;
      e.es  = es;
      e.ec  = ec;
      e.gnt = (ev == 1) ? (8'h01 << es) : 8'h00;
      e.o   = (ev == 1) ? d[es] : 1'b0;
      e.nm  = nm;
      sb.push_back(e);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check({e.nm, " valid"}, 32'(valid), 32'(e.ev));
      check({e.nm, " gnt"},   32'(gnt),   32'(e.gnt));
      check({e.nm, " out"},   32'(out),   32'(e.o));
      if (e.es >= 0) check({e.nm, " s"},   32'(s),       32'(e.es));
      if (e.ec >= 0) check({e.nm, " cnt"}, 32'(dut.cnt), 32'(e.ec));
    end
  end

  initial begin
    rst = 1'b1;
    req = 8'hFF;
    i   = 8'hFF;

    // Reset held two cycles with everything requesting.
    step(1'b1, 8'hFF, 8'hFF, 0, 0, 0, "rst1");
    step(1'b0, 8'hFF, 8'hFF, 0, 0, 0, "rst2");

    // Full contention: 0..7 then 0 again, four cycles each, no gaps.
    for (int k = 0; k < 36; k++)
      step(1'b0, 8'hFF, (k % 2 == 1) ? 8'h5A : 8'hA5, 1, (k / 4) % 8, k % 4, "rr");
    step(1'b1, 8'h00, 8'hA5, 1, 1, 0, "rr_next");
    step(1'b0, 8'h08, 8'hFF, 0, 0, 0, "rst3");

    // Single requester re-granted at timeout with no idle gap.
    for (int k = 0; k < 11; k++)
      step(1'b0, 8'h08, 8'hA5, 1, 3, k % 4, "single");
    step(1'b1, 8'h24, 8'hA5, 1, 3, 3, "single_end");
    step(1'b0, 8'h24, 8'hA5, 0, 0, 0, "rst4");

    // Early drop of requester 2, skip to 5, then drop 5 too.
    step(1'b0, 8'h24, 8'hA5, 1, 2, 0, "g2a");
    step(1'b0, 8'h24, 8'hA5, 1, 2, 1, "g2b");
    step(1'b0, 8'h20, 8'hA5, 1, 2, 2, "g2c");
    step(1'b0, 8'h00, 8'hA5, 1, 5, 0, "g5");
    step(1'b0, 8'h00, 8'hFF, 0, -1, -1, "idle_a");
    step(1'b0, 8'h40, 8'hFF, 0, -1, -1, "idle_b");

    // Reset in the middle of a grant to requester 6.
    step(1'b0, 8'h41, 8'hA5, 1, 6, 0, "g6a");
    step(1'b0, 8'h41, 8'hA5, 1, 6, 1, "g6b");
    step(1'b1, 8'h41, 8'hA5, 1, 6, 2, "g6c");
    step(1'b0, 8'h41, 8'hA5, 0, 0, 0, "rst_mid");
    for (int k = 0; k < 4; k++)
      step(1'b0, 8'h41, 8'hA5, 1, 0, k, "post_rst");
    step(1'b0, 8'h00, 8'hA5, 1, 6, 0, "rr_to6");
    step(1'b0, 8'h00, 8'hA5, 0, -1, -1, "final_idle");

    repeat (2) @(posedge clk);
    check("scoreboard drained", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/mux8_rr_sched.md
Name: mux8_rr_sched

Overview:
Round-robin scheduler that shares one 8:1 bit-select mux among eight requesters. It arbitrates the request lines, holds each grant for a bounded burst, and drives the registered 3-bit select. The selected data bit is presented on `out`. It sits in front of the shared single-bit output path, so no requester can starve the others.

Parameters:
- MAX_HOLD, 4, maximum consecutive cycles one grant is held (legal range 1..255).
- CNT_W, 8, width of the hold counter (must satisfy 2^CNT_W > MAX_HOLD-1).

Ports:
- clk      input   1  clock; all state updates on rising edge.
- rst      input   1  synchronous, active-high reset.
- req      input   8  request lines; bit k = requester k wants the mux.
- i        input   8  data bits; i[k] belongs to requester k.
- gnt      output  8  one-hot registered grant; all zero when idle.
- s        output  3  registered mux select = index of granted requester.
- valid    output  1  registered; 1 while a grant is active.
- out      output  1  i[s] when valid=1, else 0 (combinational from registered s/valid).

Behaviour:
- Reset (rst=1 at a clk edge, wins over everything, including mid-grant):
  - gnt=0, s=0, valid=0, state=IDLE, ptr=0, cnt=0.
  - `out` therefore reads 0 in the cycle after reset.
- State IDLE (valid=0):
  - If req==0, stay IDLE.
  - Otherwise pick the first set req bit searching upward from ptr, wrapping 7->0.
  - Next cycle: state=GRANT, s=winner, gnt=1<<winner, valid=1, cnt=0.
  - Request-to-grant latency is exactly 1 cycle.
- State GRANT (valid=1):
  - cnt counts cycles already held; it is 0 in the first granted cycle.
  - Release when req[s]==0, or when cnt==MAX_HOLD-1 with req[s] still high.
  - No release: cnt<=cnt+1; gnt, s and valid hold.
  - On release, in the same cycle:
    - ptr<=s+1 (mod 8).
    - Re-arbitrate, searching from s+1 with wrap, over the current req vector.
    - If a winner exists, the next cycle grants it with cnt=0: back-to-back, no idle gap.
    - If no winner exists, the next cycle is IDLE with gnt=0 and valid=0.
  - On timeout with no other requester, the search wraps back to s. The same requester is re-granted, so gnt stays continuous and cnt restarts at 0.
  - A requester that drops req is observed one cycle late. gnt stays high for exactly one cycle after its req falls; the requester must tolerate this.
- Fairness:
  - A continuously requesting port waits at most 7*MAX_HOLD cycles after losing the grant.
  - The burst is at most MAX_HOLD cycles per grant.
- Simultaneous events:
  - Requests arriving in a release cycle take part in that cycle's arbitration.
  - req changes in non-release cycles do not affect the current grant.
  - When MAX_HOLD=1, every granted cycle is a release cycle.
- Invariants: gnt is always one-hot or zero; gnt==(valid ? 1<<s : 0); s changes only on a release or from IDLE.
- The data path is purely combinational from the registered select. `i` is not registered; out follows i[s] in the same cycle.

Test Plan:
1. Reset sanity: rst=1 for 2 cycles with req=8'hFF and i=8'hFF -> gnt=0, s=0, valid=0, out=0. After rst falls, the first grant is gnt=8'h01 one cycle later.
2. Single requester, MAX_HOLD=4: req=8'h08 held -> one cycle later gnt=8'h08, s=3, valid=1. Re-granted every 4 cycles with no gap: valid never drops and the internal cnt sequence is 0,1,2,3,0.
3. Full contention: req=8'hFF from reset -> grants 0,1,...,7,0, each lasting exactly 4 cycles, no idle cycles.
4. Early drop and skip: req=8'h24, requester 2 granted, req[2] cleared after 2 granted cycles -> gnt=8'h04 for 3 cycles total, then gnt=8'h20 (s=5) the next cycle. Drop req[5] as well -> valid=0 and gnt=0 one cycle after it is seen low.
5. Data path: i=8'hA5 -> out=1 when s=5, out=0 when s=1, out=1 when s=0, and out=0 whenever valid=0 regardless of i.
6. Reset mid-grant: during grant to requester 6 with cnt=2, assert rst for one cycle -> next cycle gnt=0, valid=0. With req=8'h41 still high, the following grant goes to requester 0 because ptr was reset to 0.
